// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared register offsets, STATUS bit indices and TX FSM states
//               for the memory-mapped UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    localparam logic [1:0] DATA_OFS = 2'd0;
    localparam logic [1:0] STAT_OFS = 2'd1;

    localparam int BUSY    = 0;
    localparam int FULL    = 1;
    localparam int EMPTY   = 2;
    localparam int OVF     = 3;
    localparam int CNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count; dout shows the head
//               entry combinationally, push when full and pop when empty are
//               ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_mmio
// Description : Memory-mapped 8N1 UART transmitter with a byte FIFO, a STATUS
//               register and a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_mmio
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE         = 32'h0000_4000,
    parameter int          CLKS_PER_BIT = 1250,
    parameter int          DEPTH        = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        strb,
    output logic [31:0] rdata,
    output logic        tx
);

    localparam int             CW          = $clog2(DEPTH) + 1;
    localparam int             BW          = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  C_BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic          w_sel;
    logic [1:0]    w_idx;
    logic          w_wr;
    logic          w_push;
    logic          w_pop;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_head;
    logic [31:0]   w_status;
    logic          w_baud_end;
    logic          w_unused;

    uart_state_t   r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_ovf;

    assign w_sel      = (addr[31:4] == BASE[31:4]);
    assign w_idx      = addr[3:2];
    assign w_wr       = w_sel && (wmask != 4'b0000);
    assign w_push     = w_wr && (w_idx == DATA_OFS) && wmask[0];
    assign w_ovf_set  = w_push && w_full;
    assign w_ovf_clr  = w_wr && (w_idx == STAT_OFS) && wmask[0] && wdata[3];
    assign w_baud_end = (r_baud == C_BAUD_LAST);
    assign w_unused   = ^{addr[1:0], wdata[31:8]};

    // The FSM takes the head byte when idle, or at the end of a stop bit to chain frames.
    assign w_pop = !w_empty &&
                   ((r_state == IDLE) || ((r_state == STOP) && w_baud_end));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (w_push),
        .pop   (w_pop),
        .din   (wdata[7:0]),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_comb begin
        w_status                 = '0;
        w_status[BUSY]           = (r_state != IDLE);
        w_status[FULL]           = w_full;
        w_status[EMPTY]          = w_empty;
        w_status[OVF]            = r_ovf;
        w_status[CNT_LSB +: CW]  = w_count;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdata <= '0;
        end else if (strb && w_sel && (w_idx == STAT_OFS)) begin
            rdata <= w_status;
        end else begin
            rdata <= '0;
        end
    end

    // Set has priority so an overflow in the clearing cycle is not lost.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // tx is registered from the current state, so the line lags the state by one cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            tx        <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    tx <= 1'b1;
                    if (w_pop) begin
                        r_shift   <= w_head;
                        r_bit_cnt <= '0;
                        r_baud    <= '0;
                        r_state   <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                DATA: begin
                    tx <= r_shift[0];
                    if (w_baud_end) begin
                        r_baud    <= '0;
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift   <= w_head;
                            r_bit_cnt <= '0;
                            r_state   <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_mmio
// Description : Self-checking bench for uart_tx_mmio: expected tx waveform and
//               STATUS values come from a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_mmio;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_4000;

    logic        clk   = 1'b0;
    logic        rstn  = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wmask = '0;
    logic        strb  = 1'b0;
    logic [31:0] rdata;
    logic        tx;

    int errors = 0;
    int checks = 0;
    bit exp_tx[$];
    logic [7:0] q[$];

    uart_tx_mmio #(
        .BASE         (BASE),
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .addr  (addr),
        .wdata (wdata),
        .wmask (wmask),
        .strb  (strb),
        .rdata (rdata),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Each cycle, compare tx against the next expected line level (if any queued).
    task automatic tick();
        @(posedge clk);
        #1;
        if (exp_tx.size() > 0) begin
            bit e = exp_tx.pop_front();
            check("tx", {31'b0, tx}, {31'b0, e});
        end
    endtask

    task automatic drain();
        while (exp_tx.size() > 0) tick();
    endtask

    task automatic expect_idle(input int n);
        repeat (n) exp_tx.push_back(1'b1);
    endtask

    // Line image from the first write edge: two idle cycles, then gapless 8N1 frames.
    task automatic expect_frames(input logic [7:0] bytes[$]);
        logic [9:0] frame;
        expect_idle(2);
        foreach (bytes[i]) begin
            frame = {1'b1, bytes[i], 1'b0};
            for (int b = 0; b < 10; b++)
                repeat (CPB) exp_tx.push_back(frame[b]);
        end
        expect_idle(4);
    endtask

    function automatic logic [31:0] status_of(input bit busy, input bit ovf, input int count);
        logic [31:0] s;
        s    = 32'(count) << 4;
        s[0] = busy;
        s[1] = (count == DEPTH);
        s[2] = (count == 0);
        s[3] = ovf;
        return s;
    endfunction

    task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr  = a;
        wdata = d;
        wmask = m;
        tick();
        wmask = '0;
        wdata = '0;
        addr  = '0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        strb = 1'b1;
        tick();
        check(tag, rdata, exp);
        strb = 1'b0;
        addr = '0;
        tick();
        check({tag, "_hold"}, rdata, 32'h0);
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) tick();
        check("reset_tx", {31'b0, tx}, 32'h1);
        check("reset_rdata", rdata, 32'h0);
        rstn = 1'b1;

        // Idle line and idle STATUS
        expect_idle(50);
        repeat (50) tick();
        read_check("stat_idle", BASE + 32'h4, status_of(0, 0, 0));

        // Single fixed frame
        q = {8'h55};
        expect_frames(q);
        write(BASE, 32'h55, 4'b0001);
        drain();
        read_check("stat_after_55", BASE + 32'h4, status_of(0, 0, 0));

        // Back-to-back bursts: fixed first, then random lengths and bytes
        for (int r = 0; r < 4; r++) begin
            q.delete();
            if (r == 0) begin
                q = {8'hA5, 8'h3C, 8'hFF};
            end else begin
                n = $urandom_range(DEPTH + 1, 1);
                for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            end
            expect_frames(q);
            foreach (q[i]) write(BASE, {$urandom} & 32'hFFFF_FF00 | 32'(q[i]), 4'b0001);
            // First byte is taken by the transmitter the cycle after it lands.
            if (q.size() == 1)
                read_check("stat_burst", BASE + 32'h4, status_of(0, 0, 1));
            else
                read_check("stat_burst", BASE + 32'h4, status_of(1, 0, q.size() - 1));
            drain();
            read_check("stat_burst_done", BASE + 32'h4, status_of(0, 0, 0));
        end

        // Overflow: six writes while idle, only DEPTH+1 bytes survive
        q.delete();
        for (int i = 0; i < DEPTH + 2; i++) q.push_back(8'($urandom));
        begin
            logic [7:0] kept[$];
            for (int i = 0; i < DEPTH + 1; i++) kept.push_back(q[i]);
            expect_frames(kept);
        end
        foreach (q[i]) write(BASE, 32'(q[i]), 4'b0001);
        read_check("stat_ovf", BASE + 32'h4, status_of(1, 1, DEPTH));
        write(BASE + 32'h4, 32'h7, 4'b0001);
        read_check("stat_ovf_kept", BASE + 32'h4, status_of(1, 1, DEPTH));
        write(BASE + 32'h4, 32'h8, 4'b0001);
        read_check("stat_ovf_clr", BASE + 32'h4, status_of(1, 0, DEPTH));
        drain();
        read_check("stat_ovf_done", BASE + 32'h4, status_of(0, 0, 0));

        // Decode corners and ignored writes
        read_check("rd_unsel", BASE + 32'h10, 32'h0);
        read_check("rd_ofs8", BASE + 32'h8, 32'h0);
        read_check("rd_data", BASE, 32'h0);
        expect_idle(20);
        write(BASE, 32'h99, 4'b0010);
        write(BASE + 32'h8, 32'h77, 4'b1111);
        write(BASE + 32'h10, 32'h66, 4'b0001);
        drain();
        read_check("stat_ignored", BASE + 32'h4, status_of(0, 0, 0));

        // Reset in the middle of data bit 3 with two bytes queued
        q.delete();
        q.push_back(8'($urandom) & 8'hF7);
        q.push_back(8'($urandom));
        q.push_back(8'($urandom));
        expect_frames(q);
        foreach (q[i]) write(BASE, 32'(q[i]), 4'b0001);
        repeat (16) tick();
        exp_tx.delete();
        rstn = 1'b0;
        tick();
        check("tx_mid_reset", {31'b0, tx}, 32'h1);
        rstn = 1'b1;
        read_check("stat_post_reset", BASE + 32'h4, status_of(0, 0, 0));
        expect_idle(60);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
